writeback_scheduler: RTL and testbench
======================================

# writeback_scheduler

Tracks every in-flight register write between issue and retirement and drives the register-file write port (`rwin`/`rdin`/`dtowrite`) consumed by `decode`. Each issued instruction books a writeback slot `wait_time` cycles ahead. The block shifts the slots every cycle, samples the execute-side result when a slot expires, and emits one registered write per cycle. It also stops a new issue from colliding with an already booked slot, and gives decode a combinational RAW-pending query for `rs`/`rt`.

## Interface
Parameters:
- `DEPTH`, 8, number of booking slots; maximum honoured wait is `DEPTH-2`.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `issue_valid`  in  1  instruction leaves decode this cycle.
- `issue_rw`  in  2  00 none, 01 GPR, 10 FPR; same encoding as decode `rw`.
- `issue_rd`  in  5  destination register.
- `issue_wait`  in  5  extra latency W; same meaning as decode `wait_time`.
- `issue_ready`  out  1  booking accepted; combinational.
- `res_data`  in  32  result for the slot expiring this cycle.
- `q_rs`, `q_rt`  in  6  `{fpr_bit, index}` query, same format as decode `rs`/`rt`.
- `pend_rs`, `pend_rt`  out  1  a booked, not yet retired write targets the queried register.
- `wb_rw`  out  2  write-port enable; connects to `rwin`.
- `wb_rd`  out  5  connects to `rdin`.
- `wb_data`  out  32  connects to `dtowrite`.

## Operation
- Slot `i` holds `{valid, rw, rd}`.
- Every cycle, slot[i] takes slot[i+1], and slot[DEPTH-1] takes empty.
- **Effective wait:** E = min(`issue_wait`, DEPTH-2).
- **Booking rule:** an accepted issue with a real write is written into next-state slot[E]. This overrides the shifted-in value.
- **Null write:** `issue_rw`=00, or `issue_rw`=01 with `issue_rd`=0. The issue is always accepted and nothing is booked. `issue_rw`=11 is also treated as null.
- **`issue_ready`:**
  - 1 when `issue_valid`=0 or the issue is a null write.
  - Otherwise equal to !slot[E+1].valid, i.e. the target slot is free after the shift.
  - When `issue_ready`=0, the issuer holds the instruction and retries. Nothing is booked.
- **Retirement:** when slot[0].valid=1, the output register loads `wb_rw`=slot[0].rw, `wb_rd`=slot[0].rd, `wb_data`=`res_data`. When slot[0].valid=0, `wb_rw` loads 00 and `wb_rd`/`wb_data` hold their values.
- **Pending query:**
  - `pend_rs` is the OR over all valid slots of ({rw==10, rd} == `q_rs`). `pend_rt` is the same against `q_rt`.
  - Index 0 with GPR never reports pending.
  - The output register is not included; decode forwards from it.
- **WAW:** two bookings to the same register in different slots are legal. They retire in slot order.

## Timing
- **Reset:** all slots invalid; `wb_rw`=00, `wb_rd`=0, `wb_data`=0; `pend_*`=0; `issue_ready` follows its combinational rule.
- **Latency:**
  - Issue accepted in cycle n with effective wait E.
  - The slot reaches slot[0] in cycle n+1+E.
  - `res_data` must be valid in cycle n+1+E.
  - `wb_*` are visible in cycle n+2+E; the register file commits at the following edge.
- **Pending window:** `pend_*` for that register is high in cycles n+1 through n+1+E inclusive.
- **Simultaneous events:**
  - Retire and book in the same cycle are independent.
  - A booking into slot E while slot[0] retires the same `rd` is legal; the old write still retires.
- **Reset mid-operation:** all bookings are discarded immediately (async). No write is emitted until a fresh issue completes.

## Structure
- Shared package `constant`: `RW_NONE`=2'b00, `RW_GPR`=2'b01, `RW_FPR`=2'b10, and a `wb_slot_t` packed struct `{valid, rw[1:0], rd[4:0]}`.
- One sub-module, `wb_slot_match`: compares one 6-bit query against the slot array and returns a hit. It is instantiated twice, for `rs` and `rt`.

## Test plan
- **Reset:** assert `rstn`=0 mid-stream with slots booked → `wb_rw`=00 immediately. After release, no write appears and `pend_rs`=0 for previously booked r5.
- **Zero wait:** issue GPR r3, W=0 at cycle 10; drive `res_data`=0xDEADBEEF at cycle 11 → `wb_rw`=01, `wb_rd`=3, `wb_data`=0xDEADBEEF in cycle 12. `pend_rs`(q=3) is high only in cycle 11.
- **Out-of-order latency:** fadd to FPR f2 with W=5 at cycle 0, then lw to GPR r4 with W=1 at cycle 1 → r4 retires with `wb_*` at cycle 4 and f2 at cycle 7. `wb_rw` is 00 in all other cycles.
- **Collision:** book W=1 at cycle 0, then issue W=0 at cycle 1 → `issue_ready`=0. Retry at cycle 2 is accepted.
- **Null writes:** issue `rw`=01 with `rd`=0, and `rw`=00 with W=5 → `issue_ready`=1, no booking, no pending, no write.
- **Clamp and WAW:** issue W=20 with `DEPTH`=8 → behaves as W=6. Two bookings of r7 at W=3 and W=0 retire in slot order. `pend` stays high until the later one leaves slot[0].

Source files
------------

// File: rtl/writeback_scheduler_pkg.sv
// Shared write-port encodings and the booking-slot record used by the
// writeback scheduler and its query matcher.
package constant;

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_GPR  = 2'b01;
  localparam logic [1:0] RW_FPR  = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [1:0] rw;
    logic [4:0] rd;
  } wb_slot_t;

  // GPR r0 is hard-wired and 2'b11 is not a legal port code, so neither books a slot.
  function automatic logic is_real_write(input logic [1:0] rw, input logic [4:0] rd);
    return (rw == RW_FPR) || ((rw == RW_GPR) && (rd != 5'd0));
  endfunction

endpackage

// File: rtl/writeback_scheduler_match.sv
// Compares one {fpr_bit, index} register query against every booked slot
// and reports whether any outstanding write targets that register.
module wb_slot_match
  import constant::*;
#(
  parameter int DEPTH = 8
) (
  input  wb_slot_t [DEPTH-1:0] slots,
  input  logic [5:0]           query,
  output logic                 hit
);

  // GPR r0 is never pending, even though no slot should ever hold it.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slots[i].valid && ({slots[i].rw == RW_FPR, slots[i].rd} == query) && (query != 6'd0))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/writeback_scheduler.sv
// Books a writeback slot per issued instruction, shifts the slots toward
// retirement each cycle and drives the registered register-file write port.
module writeback_scheduler
  import constant::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        issue_valid,
  input  logic [1:0]  issue_rw,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  issue_wait,
  output logic        issue_ready,
  input  logic [31:0] res_data,
  input  logic [5:0]  q_rs,
  input  logic [5:0]  q_rt,
  output logic        pend_rs,
  output logic        pend_rt,
  output logic [1:0]  wb_rw,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int MAX_WAIT = DEPTH - 2;

  wb_slot_t [DEPTH-1:0] slots;
  wb_slot_t [DEPTH-1:0] slots_next;
  logic [4:0]           eff_wait;
  logic                 real_write;
  logic                 target_busy;
  logic                 book;

  always_comb begin
    eff_wait = issue_wait;
    if (int'(issue_wait) > MAX_WAIT)
      eff_wait = 5'(MAX_WAIT);
  end

  assign real_write = is_real_write(issue_rw, issue_rd);

  // The booked entry lands in slot E after this edge, which is whatever sits in slot E+1 now.
  always_comb begin
    target_busy = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      if (i == int'(eff_wait) + 1)
        target_busy = slots[i].valid;
    end
  end

  assign issue_ready = !issue_valid || !real_write || !target_busy;
  assign book        = issue_valid && real_write && !target_busy;

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++)
      slots_next[i] = slots[i+1];
    slots_next[DEPTH-1] = '0;
    if (book) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(eff_wait)) begin
          slots_next[i].valid = 1'b1;
          slots_next[i].rw    = issue_rw;
          slots_next[i].rd    = issue_rd;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      slots <= '0;
    else
      slots <= slots_next;
  end

  // Idle cycles only drop the enable; rd/data keep their last value for decode forwarding.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_rw   <= RW_NONE;
      wb_rd   <= 5'd0;
      wb_data <= 32'd0;
    end else if (slots[0].valid) begin
      wb_rw   <= slots[0].rw;
      wb_rd   <= slots[0].rd;
      wb_data <= res_data;
    end else begin
      wb_rw   <= RW_NONE;
    end
  end

  wb_slot_match #(.DEPTH(DEPTH)) u_match_rs (
    .slots (slots),
    .query (q_rs),
    .hit   (pend_rs)
  );

  wb_slot_match #(.DEPTH(DEPTH)) u_match_rt (
    .slots (slots),
    .query (q_rt),
    .hit   (pend_rt)
  );

endmodule

// File: tb/tb_writeback_scheduler.sv
// Scoreboard bench for writeback_scheduler: a booking-list model predicts
// readiness, pending flags and the retired write stream.
module tb_writeback_scheduler;
  import constant::*;

  localparam int DEPTH    = 8;
  localparam int MAX_WAIT = DEPTH - 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        issue_valid;
  logic [1:0]  issue_rw;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_wait;
  logic        issue_ready;
  logic [31:0] res_data;
  logic [5:0]  q_rs;
  logic [5:0]  q_rt;
  logic        pend_rs;
  logic        pend_rt;
  logic [1:0]  wb_rw;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  writeback_scheduler #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .issue_valid (issue_valid),
    .issue_rw    (issue_rw),
    .issue_rd    (issue_rd),
    .issue_wait  (issue_wait),
    .issue_ready (issue_ready),
    .res_data    (res_data),
    .q_rs        (q_rs),
    .q_rt        (q_rt),
    .pend_rs     (pend_rs),
    .pend_rt     (pend_rt),
    .wb_rw       (wb_rw),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         issue_cyc;
    int         retire_cyc;
    logic [1:0] rw;
    logic [4:0] rd;
  } booking_t;

  typedef struct {
    int          out_cyc;
    logic [1:0]  rw;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  booking_t    bookings[$];
  wb_exp_t     sb[$];
  wb_exp_t     mon_e;
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;
  int          override_cyc = -1;
  logic [31:0] salt;
  logic        model_ready = 1'b1;
  bit          running = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp)
      passed++;
    else
      $display("[TB] FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
  endtask

  function automatic logic [31:0] data_of(input int c);
    if (c == override_cyc)
      return 32'hDEADBEEF;
    return (32'(c) * 32'h9E3779B1) ^ salt;
  endfunction

  function automatic int eff(input logic [4:0] w);
    return (int'(w) > MAX_WAIT) ? MAX_WAIT : int'(w);
  endfunction

  function automatic bit writes_reg(input logic [1:0] rw, input logic [4:0] rd);
    if (rw == 2'b10) return 1'b1;
    if (rw == 2'b01) return rd != 0;
    return 1'b0;
  endfunction

  // A booking is outstanding from the cycle after issue up to and including its retire cycle.
  function automatic bit model_pend(input logic [5:0] q);
    foreach (bookings[i])
      if (bookings[i].issue_cyc < cyc && bookings[i].retire_cyc >= cyc &&
          {bookings[i].rw == 2'b10, bookings[i].rd} == q)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic apply_stimulus(input logic v, input logic [1:0] rw, input logic [4:0] rd,
                                input logic [4:0] w, input logic [5:0] qs, input logic [5:0] qt);
    int      r;
    int      pos;
    bit      ps;
    bit      pt;
    wb_exp_t e;
    issue_valid = v;
    issue_rw    = rw;
    issue_rd    = rd;
    issue_wait  = w;
    q_rs        = qs;
    q_rt        = qt;
    res_data    = data_of(cyc);
    for (int i = bookings.size() - 1; i >= 0; i--)
      if (bookings[i].retire_cyc < cyc) bookings.delete(i);
    r = cyc + 1 + eff(w);
    model_ready = 1'b1;
    if (v && writes_reg(rw, rd))
      foreach (bookings[i])
        if (bookings[i].retire_cyc == r) model_ready = 1'b0;
    ps = model_pend(qs);
    pt = model_pend(qt);
    if (v && writes_reg(rw, rd) && model_ready) begin
      bookings.push_back('{issue_cyc: cyc, retire_cyc: r, rw: rw, rd: rd});
      e = '{out_cyc: r + 1, rw: rw, rd: rd, data: data_of(r)};
      pos = sb.size();
      for (int i = 0; i < sb.size(); i++)
        if (sb[i].out_cyc > e.out_cyc && pos == sb.size()) pos = i;
      sb.insert(pos, e);
    end
    @(negedge clk);
    check_output("issue_ready", 32'(issue_ready), 32'(model_ready));
    check_output("pend_rs", 32'(pend_rs), 32'(ps));
    check_output("pend_rt", 32'(pend_rt), 32'(pt));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic [5:0] qs, input logic [5:0] qt);
    for (int i = 0; i < n; i++)
      apply_stimulus(1'b0, 2'b00, 5'd0, 5'd0, qs, qt);
  endtask

  task automatic reset_mid(input logic [5:0] q);
    issue_valid = 1'b0;
    q_rs = q;
    q_rt = q;
    rstn = 1'b0;
    #1;
    check_output("rst_wb_rw", 32'(wb_rw), 32'(RW_NONE));
    check_output("rst_wb_rd", 32'(wb_rd), 32'd0);
    check_output("rst_wb_data", wb_data, 32'd0);
    check_output("rst_pend_rs", 32'(pend_rs), 32'd0);
    bookings.delete();
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc++;
  endtask

  // Monitor: every live cycle either a scheduled write is due or the port must be idle.
  always @(negedge clk) begin
    if (running && rstn) begin
      while (sb.size() > 0 && sb[0].out_cyc < cyc) begin
        checks++;
        $display("[TB] FAIL wb_missed cyc=%0d actual=none expected_cyc=%0d", cyc, sb[0].out_cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].out_cyc == cyc) begin
        mon_e = sb.pop_front();
        check_output("wb_rw", 32'(wb_rw), 32'(mon_e.rw));
        check_output("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
        check_output("wb_data", wb_data, mon_e.data);
      end else begin
        check_output("wb_idle", 32'(wb_rw), 32'(RW_NONE));
      end
    end
  end

  logic       hv;
  logic [1:0] hrw;
  logic [4:0] hrd;
  logic [4:0] hw;

  initial begin
    rstn = 1'b0;
    issue_valid = 1'b0;
    issue_rw = 2'b00;
    issue_rd = 5'd0;
    issue_wait = 5'd0;
    res_data = 32'd0;
    q_rs = 6'd5;
    q_rt = 6'h22;
    salt = $urandom;
    hv = 1'b0;
    hrw = 2'b00;
    hrd = 5'd0;
    hw = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_wb_rw", 32'(wb_rw), 32'(RW_NONE));
    check_output("reset_wb_rd", 32'(wb_rd), 32'd0);
    check_output("reset_wb_data", wb_data, 32'd0);
    check_output("reset_pend_rs", 32'(pend_rs), 32'd0);
    check_output("reset_pend_rt", 32'(pend_rt), 32'd0);
    check_output("reset_ready", 32'(issue_ready), 32'd1);
    rstn = 1'b1;
    running = 1'b1;
    cyc = 0;

    // Zero wait: r3 retires with the value driven one cycle after issue.
    override_cyc = cyc + 1;
    apply_stimulus(1'b1, RW_GPR, 5'd3, 5'd0, 6'd3, 6'd3);
    idle(4, 6'd3, 6'd3);

    // Out-of-order latency: f2 with W=5 then r4 with W=1.
    apply_stimulus(1'b1, RW_FPR, 5'd2, 5'd5, 6'h22, 6'd4);
    apply_stimulus(1'b1, RW_GPR, 5'd4, 5'd1, 6'h22, 6'd4);
    idle(8, 6'h22, 6'd4);

    // Collision with a slot booked the cycle before, then a successful retry.
    apply_stimulus(1'b1, RW_GPR, 5'd9, 5'd1, 6'd9, 6'd10);
    apply_stimulus(1'b1, RW_GPR, 5'd10, 5'd0, 6'd9, 6'd10);
    apply_stimulus(1'b1, RW_GPR, 5'd10, 5'd0, 6'd9, 6'd10);
    idle(4, 6'd9, 6'd10);

    // Null writes never book, never block and never show up as pending.
    apply_stimulus(1'b1, RW_GPR, 5'd0, 5'd3, 6'd0, 6'd5);
    apply_stimulus(1'b1, RW_NONE, 5'd5, 5'd5, 6'd0, 6'd5);
    apply_stimulus(1'b1, 2'b11, 5'd5, 5'd2, 6'd0, 6'd5);
    idle(8, 6'd0, 6'd5);

    // Clamped wait plus two overlapping bookings of r7.
    apply_stimulus(1'b1, RW_GPR, 5'd11, 5'd20, 6'd7, 6'd11);
    apply_stimulus(1'b1, RW_GPR, 5'd7, 5'd3, 6'd7, 6'd11);
    apply_stimulus(1'b1, RW_GPR, 5'd7, 5'd0, 6'd7, 6'd11);
    idle(9, 6'd7, 6'd11);

    // Reset while r5 is outstanding and r6 is on the write port.
    apply_stimulus(1'b1, RW_GPR, 5'd5, 5'd6, 6'd5, 6'd6);
    apply_stimulus(1'b1, RW_GPR, 5'd6, 5'd0, 6'd5, 6'd6);
    idle(1, 6'd5, 6'd6);
    reset_mid(6'd5);
    idle(10, 6'd5, 6'd6);

    // Random traffic; a rejected issue is held and retried like a stalled decode.
    for (int n = 0; n < 1500; n++) begin
      if (!(hv && !model_ready)) begin
        hv  = ($urandom_range(0, 3) != 0);
        hrw = 2'($urandom_range(0, 3));
        hrd = 5'($urandom_range(0, 7));
        hw  = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 9));
      end
      apply_stimulus(hv, hrw, hrd, hw,
                     {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7))},
                     {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7))});
    end

    idle(10, 6'd0, 6'd0);
    check_output("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
